// File: rtl/ifft_cp_pkg.sv
// ifft_cp_pkg: default sizing and read-FSM encoding for the IFFT cyclic-prefix inserter
package ifft_cp_pkg;
  localparam int DEF_WIDTH = 26;
  localparam int DEF_N = 2048;
  localparam int DEF_CP_LEN = 144;
  localparam int DEF_ADDR_W = 11;
  typedef enum logic [1:0] {IDLE = 2'b00, CP = 2'b01, BODY = 2'b10} rd_state_t;
endpackage

// File: rtl/cp_frame_ram.sv
// cp_frame_ram: dual-bank simple dual-port frame RAM with a registered read port
module cp_frame_ram #(
  parameter int DW = 52,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // array write, contents are never reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read stage; cleared on reset so the sample outputs read 0
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ifft_cp_insert.sv
// ifft_cp_insert: collects addressed IFFT samples into ping-pong banks and replays each symbol with a cyclic prefix
module ifft_cp_insert
  import ifft_cp_pkg::*;
#(
  parameter int WIDTH = ifft_cp_pkg::DEF_WIDTH,
  parameter int N = ifft_cp_pkg::DEF_N,
  parameter int CP_LEN = ifft_cp_pkg::DEF_CP_LEN,
  parameter int ADDR_W = ifft_cp_pkg::DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic signed [WIDTH-1:0] data_in_r,
  input  logic signed [WIDTH-1:0] data_in_i,
  output logic                    out_valid,
  output logic                    out_sos,
  output logic                    out_cp,
  output logic signed [WIDTH-1:0] data_out_r,
  output logic signed [WIDTH-1:0] data_out_i,
  output logic                    overflow
);
  localparam logic [ADDR_W-1:0] CP_START = ADDR_W'(N - CP_LEN);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  rd_state_t state;
  logic [1:0] full, full_nx;
  logic wbank, rbank, rel, wr_ok, wr_last;
  logic [ADDR_W-1:0] wcnt, raddr;
  assign rel = (state == BODY) && (raddr == LAST);
  // a bank being released this cycle may be written in the same cycle
  assign wr_ok = in_valid && (!full[wbank] || (rel && (rbank == wbank)));
  assign wr_last = wr_ok && (wcnt == LAST);
  assign full_nx = (full & ~(rel ? (2'b01 << rbank) : 2'b00)) | (wr_last ? (2'b01 << wbank) : 2'b00);
  // write side: sample count, bank flags, sticky drop flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= '0;
      wbank <= 1'b0;
      wcnt <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_nx;
      if (wr_ok) wcnt <= wr_last ? '0 : wcnt + 1'b1;
      if (wr_last) wbank <= ~wbank;
      if (in_valid && !wr_ok) overflow <= 1'b1;
    end
  // read FSM: prefix then body, chaining straight into the next full bank
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      raddr <= '0;
      rbank <= 1'b0;
      out_valid <= 1'b0;
      out_sos <= 1'b0;
      out_cp <= 1'b0;
    end else begin
      out_valid <= state != IDLE;
      out_sos <= (state == CP) && (raddr == CP_START);
      out_cp <= state == CP;
      case (state)
        IDLE:
          if (full[rbank]) begin
            state <= CP;
            raddr <= CP_START;
          end
        CP: begin
          raddr <= raddr + 1'b1;
          if (raddr == LAST) state <= BODY;
        end
        BODY: begin
          raddr <= raddr + 1'b1;
          if (rel) begin
            rbank <= ~rbank;
            state <= full_nx[~rbank] ? CP : IDLE;
            raddr <= full_nx[~rbank] ? CP_START : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  cp_frame_ram #(.DW(2 * WIDTH), .AW(ADDR_W + 1)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(wr_ok),
    .waddr({wbank, in_addr}),
    .wdata({data_in_r, data_in_i}),
    .re(state != IDLE),
    .raddr({rbank, raddr}),
    .rdata({data_out_r, data_out_i})
  );
endmodule

// File: tb/tb_ifft_cp_insert.sv
// tb_ifft_cp_insert: directed vector bench for the cyclic-prefix inserter
module tb_ifft_cp_insert;
  localparam int W = 26, N = 16, CPL = 4, AW = 4, SYM = N + CPL;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic signed [W-1:0] data_in_r = '0, data_in_i = '0;
  logic out_valid, out_sos, out_cp, overflow;
  logic signed [W-1:0] data_out_r, data_out_i;
  ifft_cp_insert #(.WIDTH(W), .N(N), .CP_LEN(CPL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
    .data_in_r(data_in_r), .data_in_i(data_in_i), .out_valid(out_valid),
    .out_sos(out_sos), .out_cp(out_cp), .data_out_r(data_out_r),
    .data_out_i(data_out_i), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int q_r[$], q_i[$], q_f[$], q_c[$];
  // capture every valid output sample on the falling edge
  always @(negedge clk)
    if (out_valid) begin
      q_r.push_back(int'(data_out_r));
      q_i.push_back(int'(data_out_i));
      q_f.push_back(int'({out_cp, out_sos}));
      q_c.push_back(cyc);
    end
  int n_chk = 0, n_fail = 0;
  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic clr();
    q_r.delete(); q_i.delete(); q_f.delete(); q_c.delete();
  endtask
  function automatic int xaddr(bit scr, int k);
    return scr ? (((k & 3) << 2) | (k >> 2)) : k;
  endfunction
  task automatic send_rng(bit scr, int base, bit negi, int k0, int k1, output int last);
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_addr = AW'(xaddr(scr, k));
      data_in_r = W'(base + xaddr(scr, k));
      data_in_i = negi ? W'(-xaddr(scr, k)) : '0;
      last = cyc + 1;
    end
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask
  task automatic wait_out(int n, int budget);
    int t = 0;
    while (q_r.size() < n && t < budget) begin
      @(negedge clk);
      in_valid = 1'b0;
      t++;
    end
    idle(4);
  endtask
  task automatic chk_sym(string nm, int off, int base, bit negi);
    if (q_r.size() < off + SYM) begin
      chk({nm, "_len"}, q_r.size(), off + SYM);
      return;
    end
    for (int j = 0; j < SYM; j++) begin
      int idx = j < CPL ? N - CPL + j : j - CPL;
      chk($sformatf("%s_r%0d", nm, j), q_r[off + j], base + idx);
      chk($sformatf("%s_i%0d", nm, j), q_i[off + j], negi ? -idx : 0);
      chk($sformatf("%s_f%0d", nm, j), q_f[off + j], (j < CPL ? 2 : 0) | (j == 0 ? 1 : 0));
    end
  endtask
  task automatic chk_run(string nm, int n, int sos);
    int s = 0;
    chk({nm, "_count"}, q_r.size(), n);
    if (q_c.size() == n) chk({nm, "_contig"}, q_c[n - 1] - q_c[0], n - 1);
    foreach (q_f[j]) s += q_f[j] & 1;
    chk({nm, "_sos"}, s, sos);
  endtask
  typedef struct {
    bit scr;
    int base;
    bit negi;
    int lat;
    int cnt;
  } vec_t;
  vec_t vt[5];
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int last, l2, l3;
    vt[0] = '{1'b0, 0, 1'b1, 2, SYM};
    vt[1] = '{1'b1, 100, 1'b0, 2, SYM};
    vt[2] = '{1'b0, 33554416, 1'b1, 2, SYM};
    vt[3] = '{1'b1, -33554432, 1'b0, 2, SYM};
    vt[4] = '{1'b0, -7, 1'b1, 2, SYM};
    repeat (2) @(negedge clk);
    chk("reset_outs", int'({out_valid, out_sos, out_cp, overflow}), 0);
    chk("reset_data", int'(data_out_r) | int'(data_out_i), 0);
    rst = 1'b0;
    idle(2);
    foreach (vt[v]) begin
      clr();
      send_rng(vt[v].scr, vt[v].base, vt[v].negi, 0, N - 1, last);
      wait_out(vt[v].cnt, 60);
      chk_run($sformatf("v%0d", v), vt[v].cnt, 1);
      if (q_c.size() > 0) chk($sformatf("v%0d_lat", v), q_c[0] - last, vt[v].lat);
      chk_sym($sformatf("v%0d", v), 0, vt[v].base, vt[v].negi);
      chk($sformatf("v%0d_ovf", v), int'(overflow), 0);
    end
    clr();
    for (int s = 0; s < 3; s++) begin
      send_rng(1'b0, 1000 * (s + 1), 1'b0, 0, N - 1, last);
      idle(4);
    end
    wait_out(3 * SYM, 80);
    chk_run("b2b", 3 * SYM, 3);
    for (int s = 0; s < 3; s++) chk_sym($sformatf("b2b%0d", s), s * SYM, 1000 * (s + 1), 1'b0);
    chk("b2b_ovf", int'(overflow), 0);
    clr();
    send_rng(1'b0, 200, 1'b0, 0, N - 1, last);
    send_rng(1'b0, 300, 1'b0, 0, N - 1, l2);
    send_rng(1'b0, 400, 1'b0, 0, N - 1, l3);
    wait_out(2 * SYM, 80);
    idle(10);
    chk_run("ovf_ab", 2 * SYM, 2);
    chk_sym("ovf_a", 0, 200, 1'b0);
    chk_sym("ovf_b", SYM, 300, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    clr();
    send_rng(1'b0, 400, 1'b0, 0, CPL - 1, last);
    wait_out(SYM, 60);
    chk_run("ovf_c", SYM, 1);
    if (q_c.size() > 0) chk("ovf_c_lat", q_c[0] - last, 2);
    chk_sym("ovf_c", 0, 400, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_ovf_clr", int'(overflow), 0);
    clr();
    send_rng(1'b0, 500, 1'b1, 0, N - 1, last);
    send_rng(1'b0, 600, 1'b1, 0, N - 1, l2);
    idle(4);
    send_rng(1'b0, 700, 1'b1, 0, N - 1, l3);
    wait_out(3 * SYM, 90);
    chk_run("coll", 3 * SYM, 3);
    chk_sym("coll_a", 0, 500, 1'b1);
    chk_sym("coll_b", SYM, 600, 1'b1);
    chk_sym("coll_c", 2 * SYM, 700, 1'b1);
    chk("coll_ovf", int'(overflow), 0);
    clr();
    send_rng(1'b0, 800, 1'b0, 0, N - 1, last);
    send_rng(1'b0, 900, 1'b0, 0, 4, l2);
    idle(4);
    chk("mid_valid", int'(out_valid), 1);
    chk("mid_cp", int'(out_cp), 0);
    #1 rst = 1'b1;
    #1 chk("rst_async_outs", int'({out_valid, out_sos, out_cp, overflow}), 0);
    chk("rst_async_data", int'(data_out_r) | int'(data_out_i), 0);
    @(negedge clk) rst = 1'b0;
    idle(2);
    clr();
    send_rng(vt[0].scr, vt[0].base, vt[0].negi, 0, N - 1, last);
    wait_out(SYM, 60);
    chk_run("after_rst", SYM, 1);
    if (q_c.size() > 0) chk("after_rst_lat", q_c[0] - last, 2);
    chk_sym("after_rst", 0, vt[0].base, vt[0].negi);
    chk("after_rst_ovf", int'(overflow), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
